// File: rtl/arbiter_pkg.sv
// rtl/arbiter_pkg.sv - shared types and helpers for the request/grant arbiter
package arbiter_pkg;

   typedef enum logic {ARB_IDLE, ARB_OWNED} arb_state_e;

   localparam logic ARB_MODE_FIXED = 1'b0;
   localparam logic ARB_MODE_RR    = 1'b1;

   // Index of the set bit of a one-hot vector; 0 when the vector is empty.
   function automatic logic [4:0] onehot2idx(input logic [31:0] oh);
      logic [4:0] idx;
      idx = '0;
      for (int i = 0; i < 32; i++)
         if (oh[i]) idx = idx | 5'(i);
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational winner pick, fixed priority or round-robin from ptr+1
module rr_pick #(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req_masked,
   input  logic [IDW-1:0] ptr,
   input  logic           rr_en,
   output logic           win_valid,
   output logic [IDW-1:0] win_idx
);

   logic [N-1:0] rot;
   int           start;

   // Rotating a doubled copy puts the scan start at bit 0, so a plain
   // lowest-bit priority encode gives the wrap-around winner.
   always_comb begin
      start     = rr_en ? (int'(ptr) + 1) % N : 0;
      rot       = N'({req_masked, req_masked} >> start);
      win_valid = |req_masked;
      win_idx   = '0;
      for (int i = N - 1; i >= 0; i--)
         if (rot[i]) win_idx = IDW'((start + i) % N);
   end

endmodule

// File: rtl/arbiter_rr.sv
// rtl/arbiter_rr.sv - N-way registered one-hot arbiter, fixed or round-robin, with hold limit
module arbiter_rr
   import arbiter_pkg::*;
#(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8,
   parameter int IDW      = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           mode_rr,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic           gnt_valid,
   output logic [IDW-1:0] gnt_id
);

   localparam int            HW       = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

   arb_state_e     state, state_n;
   logic [HW-1:0]  hold_cnt, hold_n;
   logic [IDW-1:0] rr_ptr, ptr_n;
   logic [N-1:0]   gnt_n, others, pick_mask;
   logic           owner_req, preempt, rr_en, win_valid, take, drop;
   logic [IDW-1:0] win_idx;

   assign rr_en     = (mode_rr == ARB_MODE_RR);
   assign others    = req & ~gnt;
   assign owner_req = |(req & gnt);
   assign preempt   = (state == ARB_OWNED) && owner_req && (|others) &&
                      (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX);
   // On preemption the current owner is excluded from the pick.
   assign pick_mask = preempt ? others : req;

   rr_pick #(.N(N), .IDW(IDW)) u_pick (
      .req_masked (pick_mask),
      .ptr        (rr_ptr),
      .rr_en      (rr_en),
      .win_valid  (win_valid),
      .win_idx    (win_idx)
   );

   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      hold_n  = hold_cnt;
      ptr_n   = rr_ptr;
      take    = 1'b0;
      drop    = 1'b0;
      case (state)
         ARB_IDLE: take = win_valid;
         ARB_OWNED: begin
            if (owner_req && !preempt) begin
               // Hold only counts while someone else is waiting.
               if (!(|others) || MAX_HOLD == 0) hold_n = HW'(1);
               else if (hold_cnt != HOLD_MAX)    hold_n = hold_cnt + 1'b1;
            end else if (win_valid) begin
               take = 1'b1;
            end else begin
               drop = 1'b1;
            end
         end
         default: drop = 1'b1;
      endcase
      if (take) begin
         state_n = ARB_OWNED;
         gnt_n   = N'(1) << win_idx;
         hold_n  = HW'(1);
         ptr_n   = win_idx;
      end
      if (drop) begin
         state_n = ARB_IDLE;
         gnt_n   = '0;
         hold_n  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ARB_IDLE;
         gnt       <= '0;
         gnt_valid <= 1'b0;
         gnt_id    <= '0;
         hold_cnt  <= '0;
         rr_ptr    <= IDW'(N - 1);
      end else begin
         state     <= state_n;
         gnt       <= gnt_n;
         gnt_valid <= |gnt_n;
         gnt_id    <= IDW'(onehot2idx(32'(gnt_n)));
         hold_cnt  <= hold_n;
         rr_ptr    <= ptr_n;
      end
   end

endmodule
